mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  CPU-side bus sequencer sitting directly upstream of memory_bus. Takes one
//  8- or 16-bit read/write request from the execute stage and turns it into
//  one or two byte accesses on the 8-bit memory bus (little-endian: low byte
//  at addr, high byte at addr+1). Inserts fixed wait states to cover the
//  one-cycle latency of the block RAM/ROM and peripheral registers.
// PARAMETERS
//  WAIT_STATES  1  extra cycles each byte access holds address before sampling (>=1)
// PORTS
//  clk               in   1   system clock; all state changes on rising edge
//  reset             in   1   asynchronous, active-high reset
//  req_valid         in   1   request present
//  req_ready         out  1   unit idle; request accepted when valid&ready at clk edge
//  req_write         in   1   1=write, 0=read
//  req_word          in   1   1=16-bit access, 0=8-bit access
//  req_address       in   16  byte address
//  req_data          in   16  write data; [7:0] only for byte writes
//  resp_valid        out  1   one-cycle pulse: access complete (reads and writes)
//  resp_data         out  16  read data; {8'h00,byte} for byte reads; held until next resp
//  bus_address       out  16  to memory_bus address
//  bus_data_out      out  8   to memory_bus data_in
//  bus_data_in       in   8   from memory_bus data_out
//  bus_enable        out  1   to memory_bus bus_enable
//  bus_write_enable  out  1   to memory_bus write_enable
// BEHAVIOUR
//  - Reset (async): state=IDLE; bus_address, bus_data_out, resp_data = 0;
//    bus_enable, bus_write_enable, resp_valid = 0. req_ready = (state==IDLE) & ~reset.
//  - FSM: IDLE -> BYTE0 -> [BYTE1 if word] -> DONE -> IDLE.
//  - IDLE: req_ready=1. On valid&ready latch write, word, address, data; set
//    bus_address=req_address, bus_data_out=req_data[7:0]; wait counter=WAIT_STATES.
//  - BYTE0/BYTE1: each lasts exactly WAIT_STATES+1 cycles with bus_enable=1 and
//    bus_address/bus_data_out stable. bus_write_enable=1 only in the last cycle
//    of a write byte (exactly one pulse per byte). Reads sample bus_data_in at
//    the clk edge ending the last cycle.
//  - BYTE1 address = latched address + 1, mod 2^16 (0xFFFF wraps to 0x0000);
//    bus_data_out = req_data[15:8].
//  - DONE: one cycle, bus_enable=0, bus_write_enable=0, resp_valid=1, resp_data
//    updated for reads ({hi,lo} or {8'h00,lo}); writes leave resp_data unchanged.
//  - Latency (accept edge at cycle n): byte op resp_valid in cycle n+WAIT_STATES+2;
//    word op in cycle n+2*WAIT_STATES+3. W=1: byte n+3, word n+5.
//  - req_ready=0 in BYTE0/BYTE1/DONE; inputs ignored there (no queueing).
//    Next request earliest accepted in the IDLE cycle after DONE.
//  - bus_address holds its last value in IDLE/DONE; bus_enable=0 there.
//  - Reset mid-operation: access aborted at once, bus_enable/bus_write_enable
//    drop asynchronously, no resp_valid. A word write aborted in BYTE1 may
//    leave the low byte written; this is accepted behaviour.
// TESTING
//  1 Byte read, W=1: mem[0x0010]=0xA5, req rd byte @0x0010 -> bus_enable 2 cycles
//    @0x0010, resp_valid at n+3, resp_data=0x00A5.
//  2 Word write 0xBEEF @0xC100 -> bus_write_enable one pulse @0xC100 data 0xEF,
//    one pulse @0xC101 data 0xBE; word read back -> 0xBEEF at n+5.
//  3 Word read @0xFFFF: mem[0xFFFF]=0x34, mem[0x0000]=0x12 -> second access
//    @0x0000, resp_data=0x1234.
//  4 W=3 byte write @0x8002 data 0x5A -> bus_enable 4 cycles, write pulse only in
//    4th, resp_valid at n+5; req_valid held high during op accepted only after DONE.
//  5 Assert reset during BYTE1 of word write -> bus_enable, bus_write_enable,
//    resp_valid 0 immediately; high byte not written; req_ready=1 after release.
//  6 Back-to-back: two byte reads with req_valid held -> second accept exactly one
//    cycle after first resp_valid; resp_data holds first value until second DONE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Bus sequencer: splits 8/16-bit CPU requests into byte accesses on an
// 8-bit memory bus, holding each address for a fixed number of wait states.
module mem_access_unit #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_address,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        bus_enable,
  output logic        bus_write_enable
);

  localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_STATES);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          lat_write;
  logic          lat_word;
  logic [15:0]   lat_addr;
  logic [7:0]    lat_hi;
  logic [7:0]    lo_byte;

  assign req_ready = (state == IDLE) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      lat_write        <= 1'b0;
      lat_word         <= 1'b0;
      lat_addr         <= '0;
      lat_hi           <= '0;
      lo_byte          <= '0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      bus_address      <= '0;
      bus_data_out     <= '0;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            lat_write        <= req_write;
            lat_word         <= req_word;
            lat_addr         <= req_address;
            lat_hi           <= req_data[15:8];
            bus_address      <= req_address;
            bus_data_out     <= req_data[7:0];
            bus_enable       <= 1'b1;
            bus_write_enable <= 1'b0;
            wait_cnt         <= WAIT_INIT;
            state            <= BYTE0;
          end
        end
        BYTE0, BYTE1: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_ONE;
            // strobe lands in the final cycle of the byte access only
            bus_write_enable <= lat_write && (wait_cnt == WAIT_ONE);
          end else begin
            bus_write_enable <= 1'b0;
            if (state == BYTE0 && lat_word) begin
              lo_byte      <= bus_data_in;
              bus_address  <= lat_addr + 16'd1;
              bus_data_out <= lat_hi;
              wait_cnt     <= WAIT_INIT;
              state        <= BYTE1;
            end else begin
              bus_enable <= 1'b0;
              resp_valid <= 1'b1;
              if (!lat_write) begin
                if (state == BYTE1)
                  resp_data <= {bus_data_in, lo_byte};
                else
                  resp_data <= {8'h00, bus_data_in};
              end
              state <= DONE;
            end
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (1 and 3 wait states) on a
// shared byte memory, checked cycle by cycle against a timing/data model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic        req_word [2];
  logic [15:0] req_address [2];
  logic [15:0] req_data [2];
  logic        resp_valid [2];
  logic [15:0] resp_data [2];
  logic [15:0] bus_address [2];
  logic [7:0]  bus_data_out [2];
  logic [7:0]  bus_data_in [2];
  logic        bus_enable [2];
  logic        bus_write_enable [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WAIT_STATES(1)) u_w1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_word(req_word[0]),
    .req_address(req_address[0]), .req_data(req_data[0]),
    .resp_valid(resp_valid[0]), .resp_data(resp_data[0]),
    .bus_address(bus_address[0]), .bus_data_out(bus_data_out[0]),
    .bus_data_in(bus_data_in[0]), .bus_enable(bus_enable[0]),
    .bus_write_enable(bus_write_enable[0])
  );

  mem_access_unit #(.WAIT_STATES(3)) u_w3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_word(req_word[1]),
    .req_address(req_address[1]), .req_data(req_data[1]),
    .resp_valid(resp_valid[1]), .resp_data(resp_data[1]),
    .bus_address(bus_address[1]), .bus_data_out(bus_data_out[1]),
    .bus_data_in(bus_data_in[1]), .bus_enable(bus_enable[1]),
    .bus_write_enable(bus_write_enable[1])
  );

  // shared memory with one-cycle read latency
  logic [7:0] mem [65536];
  bit         written [65536];

  function automatic logic [7:0] init_byte(logic [15:0] a);
    return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'h5C;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (bus_enable[u] && bus_write_enable[u]) begin
        mem[bus_address[u]]     <= bus_data_out[u];
        written[bus_address[u]] <= 1'b1;
      end
      bus_data_in[u] <= written[bus_address[u]] ?
                        mem[bus_address[u]] : init_byte(bus_address[u]);
    end
  end

  // reference memory contents as the bench expects them
  logic [7:0]  ref_mem [65536];
  bit          ref_wr [65536];
  logic [15:0] last_resp [2];

  function automatic logic [7:0] ref_rd(logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_op(input int u, input bit wr, input bit wd,
                       input logic [15:0] a, input logic [15:0] d,
                       input bit hold);
    int w;
    int lat;
    int n;
    logic [15:0] a1;
    logic [15:0] exp_resp;
    logic        en, we, rv;
    logic [15:0] ea;
    logic [7:0]  ed;
    w   = (u == 0) ? 1 : 3;
    lat = wd ? 2 * w + 3 : w + 2;
    a1  = a + 16'd1;
    @(negedge clk);
    req_write[u]   = wr;
    req_word[u]    = wd;
    req_address[u] = a;
    req_data[u]    = d;
    req_valid[u]   = 1'b1;
    n = 0;
    while (!req_ready[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_idle", {31'd0, req_ready[u]}, 32'd1);
    if (wr) begin
      ref_mem[a] = d[7:0];
      ref_wr[a]  = 1'b1;
      if (wd) begin
        ref_mem[a1] = d[15:8];
        ref_wr[a1]  = 1'b1;
      end
      exp_resp = last_resp[u];
    end else begin
      exp_resp = wd ? {ref_rd(a1), ref_rd(a)} : {8'h00, ref_rd(a)};
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid[u] = 1'b0;
      if (k <= w + 1) begin
        en = 1'b1; we = wr && (k == w + 1); ea = a; ed = d[7:0];
      end else if (wd && k <= 2 * w + 2) begin
        en = 1'b1; we = wr && (k == 2 * w + 2); ea = a1; ed = d[15:8];
      end else begin
        en = 1'b0; we = 1'b0;
        ea = wd ? a1 : a;
        ed = wd ? d[15:8] : d[7:0];
      end
      rv = (k == lat);
      check("bus", {5'd0, bus_enable[u], bus_write_enable[u], resp_valid[u],
                    bus_address[u], bus_data_out[u]},
                   {5'd0, en, we, rv, ea, ed});
      check("ready_busy", {31'd0, req_ready[u]}, 32'd0);
      if (k == lat) begin
        check("resp_data", {16'd0, resp_data[u]}, {16'd0, exp_resp});
        last_resp[u] = exp_resp;
      end else begin
        check("resp_hold", {16'd0, resp_data[u]}, {16'd0, last_resp[u]});
      end
    end
    if (!hold) req_valid[u] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_word[u] = 1'b0;
      req_address[u] = '0; req_data[u] = '0; last_resp[u] = '0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", {31'd0, req_ready[u]}, 32'd0);
      check("rst_out", {5'd0, bus_enable[u], bus_write_enable[u],
                        resp_valid[u], bus_address[u], bus_data_out[u]}, 32'd0);
      check("rst_resp", {16'd0, resp_data[u]}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready", {30'd0, req_ready[1], req_ready[0]}, 32'd3);

    // byte write then byte read
    do_op(0, 1, 0, 16'h0010, 16'h00A5, 0);
    do_op(0, 0, 0, 16'h0010, 16'h0000, 0);
    check("t1_val", {16'd0, resp_data[0]}, 32'h0000_00A5);
    // word write then word read
    do_op(0, 1, 1, 16'hC100, 16'hBEEF, 0);
    do_op(0, 0, 1, 16'hC100, 16'h0000, 0);
    check("t2_val", {16'd0, resp_data[0]}, 32'h0000_BEEF);
    // word read across the address wrap
    do_op(0, 1, 0, 16'hFFFF, 16'h0034, 0);
    do_op(0, 1, 0, 16'h0000, 16'h0012, 0);
    do_op(0, 0, 1, 16'hFFFF, 16'h0000, 0);
    check("t3_val", {16'd0, resp_data[0]}, 32'h0000_1234);
    // 3 wait states, request held across the op
    do_op(1, 1, 0, 16'h8002, 16'h005A, 1);
    do_op(1, 0, 0, 16'h8002, 16'h0000, 0);
    check("t4_val", {16'd0, resp_data[1]}, 32'h0000_005A);

    // reset during the high byte of a word write
    @(negedge clk);
    req_write[0] = 1'b1; req_word[0] = 1'b1;
    req_address[0] = 16'h4000; req_data[0] = 16'hC3D4;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_byte1", {7'd0, bus_enable[0], bus_address[0], bus_data_out[0]},
                      {7'd0, 1'b1, 16'h4001, 8'hC3});
    reset = 1'b1;
    #1;
    check("t5_abort", {29'd0, bus_enable[0], bus_write_enable[0],
                       resp_valid[0]}, 32'd0);
    check("t5_ready", {31'd0, req_ready[0]}, 32'd0);
    ref_mem[16'h4000] = 8'hD4;
    ref_wr[16'h4000]  = 1'b1;
    last_resp[0] = '0;
    last_resp[1] = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_rel", {31'd0, req_ready[0]}, 32'd1);
    check("t5_addr", {16'd0, bus_address[0]}, 32'd0);
    do_op(0, 0, 1, 16'h4000, 16'h0000, 0);

    // back-to-back reads with valid held
    do_op(0, 0, 0, 16'h0010, 16'h0000, 1);
    do_op(0, 0, 0, 16'hC101, 16'h0000, 0);
    check("t6_val", {16'd0, resp_data[0]}, 32'h0000_00BE);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      else if ($urandom_range(0, 1) == 0) ra = {12'hC10, 4'($urandom)};
      do_op(int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), ra, 16'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
